// File: rtl/alu_regbank_seq_pkg.sv
// Shared definitions for the sequenced ALU / register-bank block.
//   mode_e   : 2-bit operation class (step, ALU, bus move, NOP)
//   func_e   : 3-bit ALU function code, meaningful in ALU mode only
//   state_e  : 4-state operation sequencer
//   FLAG_*   : bit positions inside the {C,V,N,Z} flag vector
//   sel_width: width of a register index, never below 1
package alu_regbank_seq_pkg;

   typedef enum logic [1:0] {
      MODE_STEP = 2'b00,
      MODE_ALU  = 2'b01,
      MODE_MOVE = 2'b10,
      MODE_NOP  = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      FUNC_ADD = 3'b000,
      FUNC_SUB = 3'b001,
      FUNC_AND = 3'b010,
      FUNC_OR  = 3'b011,
      FUNC_XOR = 3'b100,
      FUNC_NOT = 3'b101,
      FUNC_SHL = 3'b110,
      FUNC_SHR = 3'b111
   } func_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_C = 3;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_regbank_seq_alu_nb.sv
// Combinational WIDTH-bit ALU.
//   op_a, op_b : operands
//   func       : operation select
//   res        : result, truncated to WIDTH bits
//   c          : carry (ADD), borrow (SUB), shifted-out bit (SHL/SHR), else 0
//   v          : signed overflow for ADD/SUB, else 0
module alu_nb
   import alu_regbank_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  func_e            func,
   output logic [WIDTH-1:0] res,
   output logic             c,
   output logic             v
);

   // Extra top bit holds the carry out of an add or the borrow out of a subtract.
   logic [WIDTH:0] wide;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      wide = '0;
      res  = '0;
      c    = 1'b0;
      v    = 1'b0;
      case (func)
         FUNC_ADD: begin
            wide = {1'b0, op_a} + {1'b0, op_b};
            res  = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            v    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
         end
         FUNC_SUB: begin
            wide = {1'b0, op_a} - {1'b0, op_b};
            res  = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            v    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
         end
         FUNC_AND: res = op_a & op_b;
         FUNC_OR:  res = op_a | op_b;
         FUNC_XOR: res = op_a ^ op_b;
         FUNC_NOT: res = ~op_a;
         FUNC_SHL: begin
            res = op_a << 1;
            c   = op_a[WIDTH-1];
         end
         FUNC_SHR: begin
            res = op_a >> 1;
            c   = op_a[0];
         end
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/alu_regbank_seq.sv
// Register bank with a button-sequenced ALU.
//   clk, rst   : clock, asynchronous active-high reset
//   go         : debounced button level; a rising edge in IDLE starts one op
//   mode, func : operation class and ALU function
//   dir        : step direction (0 = +1, 1 = -1)
//   src_a/src_b/dst : operand and destination register indices
//   rd_sel, rd_data : combinational display read port
//   regs_flat  : {R(NREG-1),...,R0}
//   flags      : {C,V,N,Z}
//   busy, done : busy in FETCH/EXEC/DONE, done pulses for one cycle in DONE
module alu_regbank_seq
   import alu_regbank_seq_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int NREG  = 4,
   localparam int SEL_W = sel_width(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic [1:0]            mode,
   input  logic [2:0]            func,
   input  logic                  dir,
   input  logic [SEL_W-1:0]      src_a,
   input  logic [SEL_W-1:0]      src_b,
   input  logic [SEL_W-1:0]      dst,
   input  logic [SEL_W-1:0]      rd_sel,
   output logic [WIDTH-1:0]      rd_data,
   output logic [NREG*WIDTH-1:0] regs_flat,
   output logic [3:0]            flags,
   output logic                  busy,
   output logic                  done
);

   state_e           state;
   logic             go_prev;
   mode_e            mode_q;
   func_e            func_q;
   logic             dir_q;
   logic [SEL_W-1:0] dst_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] regs [NREG];

   logic             start;
   logic [WIDTH-1:0] alu_b;
   func_e            alu_func;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;

   // go_prev resets high so a button held through reset release is not an edge.
   assign start = go && !go_prev && (state == ST_IDLE);

   // Step mode is an ADD/SUB of the constant 1.
   assign alu_b    = (mode_q == MODE_STEP) ? WIDTH'(1) : op_b_q;
   assign alu_func = (mode_q == MODE_STEP) ? (dir_q ? FUNC_SUB : FUNC_ADD) : func_q;

   alu_nb #(.WIDTH(WIDTH)) u_alu (
      .op_a (op_a_q),
      .op_b (alu_b),
      .func (alu_func),
      .res  (alu_res),
      .c    (alu_c),
      .v    (alu_v)
   );

   // Bus move bypasses the ALU and clears C and V.
   always_comb begin
      res   = alu_res;
      res_c = alu_c;
      res_v = alu_v;
      if (mode_q == MODE_MOVE) begin
         res   = op_a_q;
         res_c = 1'b0;
         res_v = 1'b0;
      end
   end

   // Out-of-range indices (non power-of-two NREG) read as zero.
   assign rd_data = (int'(rd_sel) < NREG) ? regs[rd_sel] : '0;

   for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         go_prev <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         mode_q  <= MODE_STEP;
         func_q  <= FUNC_ADD;
         dir_q   <= 1'b0;
         dst_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         flags   <= '0;
         // NOTE: the register bank is reset on purpose: the display must show zeros after reset
         // and an aborted operation must leave nothing behind.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every branch sees pre-edge state.
         go_prev <= go;
         done    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
                  busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               mode_q <= mode_e'(mode);
               func_q <= func_e'(func);
               dir_q  <= dir;
               dst_q  <= dst;
               op_a_q <= (int'(src_a) < NREG) ? regs[src_a] : '0;
               op_b_q <= (int'(src_b) < NREG) ? regs[src_b] : '0;
               state  <= ST_EXEC;
            end
            ST_EXEC: begin
               if (mode_q != MODE_NOP) begin
                  if (int'(dst_q) < NREG) regs[dst_q] <= res;
                  flags[FLAG_C] <= res_c;
                  flags[FLAG_V] <= res_v;
                  flags[FLAG_N] <= res[WIDTH-1];
                  flags[FLAG_Z] <= (res == '0);
               end
               state <= ST_DONE;
               done  <= 1'b1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_regbank_seq.sv
// Self-checking bench for alu_regbank_seq (WIDTH=4, NREG=4).
// A behavioural model computes each operation's outcome when it is issued and
// pushes it to a scoreboard queue; the entry is popped and compared when done pulses.
module tb_alu_regbank_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [1:0]  mode;
   logic [2:0]  func;
   logic        dir;
   logic [1:0]  src_a, src_b, dst, rd_sel;
   logic [3:0]  rd_data;
   logic [15:0] regs_flat;
   logic [3:0]  flags;
   logic        busy, done;

   alu_regbank_seq #(.WIDTH(4), .NREG(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .mode      (mode),
      .func      (func),
      .dir       (dir),
      .src_a     (src_a),
      .src_b     (src_b),
      .dst       (dst),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data),
      .regs_flat (regs_flat),
      .flags     (flags),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] regs;
      logic [3:0]  flags;
      logic [1:0]  dst;
      string       tag;
   } exp_t;

   exp_t       sb_q[$];
   logic [3:0] mregs [4];
   logic [3:0] mflags;
   int         checks   = 0;
   int         failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int to_signed4(input int u);
      return (u >= 8) ? u - 16 : u;
   endfunction

   // Integer reference model: signed overflow from true signed range, wrap via modulo.
   function automatic void model_op(input logic [1:0] m, input logic [2:0] f, input logic d,
                                    input logic [1:0] a, input logic [1:0] b, input logic [1:0] ds);
      int ua, ub, sa, sb, r, sr;
      bit c, v;
      ua = int'(mregs[a]);
      ub = int'(mregs[b]);
      sa = to_signed4(ua);
      sb = to_signed4(ub);
      r  = ua;
      sr = 0;
      c  = 0;
      v  = 0;
      case (m)
         2'd0: begin
            if (!d) begin r = ua + 1; sr = sa + 1; c = (r > 15); end
            else    begin r = ua - 1; sr = sa - 1; c = (ua == 0); end
            v = (sr > 7) || (sr < -8);
         end
         2'd1: begin
            case (f)
               3'd0: begin r = ua + ub; sr = sa + sb; c = (r > 15); v = (sr > 7) || (sr < -8); end
               3'd1: begin r = ua - ub; sr = sa - sb; c = (ua < ub); v = (sr > 7) || (sr < -8); end
               3'd2: r = ua & ub;
               3'd3: r = ua | ub;
               3'd4: r = ua ^ ub;
               3'd5: r = 15 - ua;
               3'd6: begin r = ua * 2; c = (ua >= 8); end
               default: begin r = ua / 2; c = (ua % 2) == 1; end
            endcase
         end
         2'd2: r = ua;
         default: r = ua;
      endcase
      r = (r + 32) % 16;
      if (m != 2'd3) begin
         mregs[ds] = 4'(r);
         mflags    = {c, v, (r >= 8), (r == 0)};
      end
   endfunction

   // Issue one operation, watch 7 edges, then compare against the scoreboard.
   // regrab raises go again while the op is in EXEC; that edge must be dropped.
   task automatic run_op(input string tag, input logic [1:0] m, input logic [2:0] f, input logic d,
                         input logic [1:0] a, input logic [1:0] b, input logic [1:0] ds, input bit regrab);
      exp_t e;
      exp_t got_e;
      int   first;
      int   dcnt;
      model_op(m, f, d, a, b, ds);
      e.regs  = {mregs[3], mregs[2], mregs[1], mregs[0]};
      e.flags = mflags;
      e.dst   = ds;
      e.tag   = tag;
      sb_q.push_back(e);
      @(negedge clk);
      mode = m; func = f; dir = d; src_a = a; src_b = b; dst = ds; rd_sel = ds; go = 1'b1;
      first = 0;
      dcnt  = 0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (done) begin
            dcnt++;
            if (first == 0) first = k;
         end
         if (k == 1) go = 1'b0;
         if (k == 2) begin
            // Operation has been latched; disturb every operand input.
            mode  = 2'($urandom);
            func  = 3'($urandom);
            dir   = 1'($urandom);
            src_a = 2'($urandom);
            src_b = 2'($urandom);
            dst   = 2'($urandom);
            if (regrab) go = 1'b1;
         end
         if (k == 3) check({tag, " rd_at_edge3"}, rd_data, e.regs[e.dst*4 +: 4]);
         if (k == 5) go = 1'b0;
      end
      check({tag, " latency"}, first, 3);
      check({tag, " done_pulses"}, dcnt, 1);
      check({tag, " busy_idle"}, busy, 1'b0);
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard_empty"}, 1, 0);
      end else begin
         got_e = sb_q.pop_front();
         check({got_e.tag, " regs_flat"}, regs_flat, got_e.regs);
         check({got_e.tag, " flags"}, flags, got_e.flags);
         check({got_e.tag, " rd_data"}, rd_data, got_e.regs[got_e.dst*4 +: 4]);
      end
   endtask

   initial begin
      rst = 1'b1; go = 1'b1;
      mode = '0; func = '0; dir = 1'b0; src_a = '0; src_b = '0; dst = '0; rd_sel = '0;
      for (int i = 0; i < 4; i++) mregs[i] = '0;
      mflags = '0;

      // Reset with go held high: release must not start an operation.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("go_held busy", busy, 1'b0);
      end
      check("reset regs_flat", regs_flat, 16'h0000);
      check("reset flags", flags, 4'h0);
      check("reset done", done, 1'b0);
      @(negedge clk);
      go = 1'b0;

      // Step wrap in both directions.
      run_op("dec_wrap", 2'd0, 3'd0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0);
      check("dec_wrap vec", {flags, regs_flat[3:0]}, {4'b1010, 4'hF});
      run_op("inc_wrap", 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
      check("inc_wrap vec", {flags, regs_flat[3:0]}, {4'b1001, 4'h0});

      // ADD 7 + 1 -> 8 with signed overflow.
      for (int i = 0; i < 7; i++) run_op("inc_r0", 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
      run_op("inc_r1", 2'd0, 3'd0, 1'b0, 2'd1, 2'd1, 2'd1, 1'b0);
      run_op("add", 2'd1, 3'd0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b0);
      check("add vec", {flags, regs_flat[11:8]}, {4'b0110, 4'h8});

      // SUB 3 - 5 -> E with borrow; SHL of 9 -> 2 with carry.
      for (int i = 0; i < 4; i++) run_op("dec_r0", 2'd0, 3'd0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) run_op("inc_r1", 2'd0, 3'd0, 1'b0, 2'd1, 2'd1, 2'd1, 1'b0);
      run_op("sub", 2'd1, 3'd1, 1'b0, 2'd0, 2'd1, 2'd3, 1'b0);
      check("sub vec", {flags, regs_flat[15:12]}, {4'b1010, 4'hE});
      run_op("inc_r2", 2'd0, 3'd0, 1'b0, 2'd2, 2'd2, 2'd2, 1'b0);
      run_op("shl", 2'd1, 3'd6, 1'b0, 2'd2, 2'd0, 2'd1, 1'b0);
      check("shl vec", {flags, regs_flat[7:4]}, {4'b1000, 4'h2});
      run_op("dec_r2", 2'd0, 3'd0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0);

      // Remaining functions on R0 = 3, R3 = E.
      for (int f = 2; f < 8; f++) begin
         if (f != 6) run_op($sformatf("func%0d", f), 2'd1, 3'(f), 1'b0, 2'd0, 2'd3, 2'd1, 1'b0);
      end

      // Bus move R2 (= 8) -> R3, then a NOP with a second go edge while busy.
      run_op("move", 2'd2, 3'd0, 1'b0, 2'd2, 2'd0, 2'd3, 1'b0);
      check("move vec", {flags, rd_data}, {4'b0010, 4'h8});
      run_op("nop_regrab", 2'd3, 3'd0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1);
      run_op("inc_regrab", 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);

      // A few random operations.
      for (int i = 0; i < 8; i++)
         run_op("random", 2'($urandom), 3'($urandom), 1'($urandom),
                2'($urandom), 2'($urandom), 2'($urandom), 1'b0);

      // Reset asserted while the operation sits in EXEC.
      @(negedge clk);
      mode = 2'd0; dir = 1'b0; src_a = 2'd0; dst = 2'd0; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort regs_flat", regs_flat, 16'h0000);
      check("abort flags", flags, 4'h0);
      for (int i = 0; i < 4; i++) mregs[i] = '0;
      mflags = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort after regs_flat", regs_flat, 16'h0000);
      check("abort after busy", busy, 1'b0);
      run_op("post_reset_inc", 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);

      check("scoreboard drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
